result_accumulator: RTL and testbench

Downstream stage of the systolic array: consumes de-skewed result rows (`ARRAY_SIZE` lanes × `ACC_WIDTH`) and accumulates partial sums across K passes into a local row buffer. On the final pass it streams the accumulated rows out over a valid/ready interface toward the output buffer or requantizer. It removes the need for the array to hold results across K tiles.

---
 rtl/tensor_pkg.sv | 20 ++
 rtl/sat_add_lane.sv | 28 ++
 rtl/result_accumulator.sv | 147 ++++++++++++++
 tb/tb_result_accumulator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_pkg.sv
// rtl/tensor_pkg.sv - shared state encoding and saturation bounds for the tensor datapath
package tensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_e;

  // Bounds are returned in 64 bits; callers size-cast to their lane width.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sat_add_lane.sv
// rtl/sat_add_lane.sv - combinational signed add of one lane with clamp to the lane range
module sat_add_lane
  import tensor_pkg::*;
#(
  parameter int ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sat
);

  localparam logic [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(ACC_WIDTH));

  logic [ACC_WIDTH-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when both operands share a sign that the result lost.
    sat = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (raw[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    sum = raw;
    if (sat) begin
      sum = a[ACC_WIDTH-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/result_accumulator.sv
// rtl/result_accumulator.sv - accumulates result rows across K passes and drains the final sums
module result_accumulator
  import tensor_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int DEPTH      = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(DEPTH+1)-1:0]       cfg_rows,
  input  logic                             cfg_first,
  input  logic                             cfg_last,
  output logic                             busy,
  output logic                             done,
  output logic                             sat_flag,
  input  logic                             in_valid,
  input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data,
  output logic                             out_last,
  input  logic                             out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = ARRAY_SIZE * ACC_WIDTH;

  acc_state_e      state_q, state_d;
  logic [CW-1:0]   rows_q, rows_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            sat_q, sat_d;

  logic [DW-1:0]   mem_q [DEPTH];
  logic            mem_wr_en;
  logic [DW-1:0]   mem_wr_data;
  logic [PW-1:0]   rd_addr;
  logic [DW-1:0]   rd_row;
  logic [DW-1:0]   add_sum;
  logic [ARRAY_SIZE-1:0] add_sat;
  logic            wr_at_end;
  logic            rd_at_end;

  // Single read port: the add operand in ACCUM, the drained row in DRAIN.
  assign rd_addr = (state_q == ST_DRAIN) ? rd_ptr_q : wr_ptr_q;
  assign rd_row  = mem_q[rd_addr];

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    sat_add_lane #(.ACC_WIDTH(ACC_WIDTH)) u_add (
      .a   (rd_row [g*ACC_WIDTH +: ACC_WIDTH]),
      .b   (in_data[g*ACC_WIDTH +: ACC_WIDTH]),
      .sum (add_sum[g*ACC_WIDTH +: ACC_WIDTH]),
      .sat (add_sat[g])
    );
  end

  assign mem_wr_data = first_q ? in_data : add_sum;
  assign wr_at_end   = (CW'(wr_ptr_q) == rows_q - CW'(1));
  assign rd_at_end   = (CW'(rd_ptr_q) == rows_q - CW'(1));

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    first_d   = first_q;
    last_d    = last_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    sat_d     = sat_q;
    mem_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_d   = cfg_rows;
          first_d  = cfg_first;
          last_d   = cfg_last;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          sat_d    = 1'b0;
          state_d  = (cfg_rows == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          mem_wr_en = 1'b1;
          wr_ptr_d  = wr_ptr_q + PW'(1);
          if (!first_q && (|add_sat)) begin
            sat_d = 1'b1;
          end
          if (wr_at_end) begin
            state_d = last_q ? ST_DRAIN : ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_at_end) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rows_q   <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      first_q  <= first_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sat_q    <= sat_d;
    end
  end

  // Row buffer is deliberately left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[wr_ptr_q] <= mem_wr_data;
    end
  end

  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_last  = (state_q == ST_DRAIN) && rd_at_end;
  assign out_data  = (state_q == ST_DRAIN) ? rd_row : '0;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_result_accumulator.sv
// tb/tb_result_accumulator.sv - randomized scoreboard bench for result_accumulator
module tb_result_accumulator;

  localparam int AS = 4;
  localparam int AW = 32;
  localparam int DP = 64;
  localparam int DW = AS * AW;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    cfg_rows = '0;
  logic          cfg_first = 1'b0;
  logic          cfg_last = 1'b0;
  logic          busy, done, sat_flag;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready = 1'b0;

  result_accumulator #(.ARRAY_SIZE(AS), .ACC_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_first(cfg_first),
    .cfg_last(cfg_last), .busy(busy), .done(done), .sat_flag(sat_flag),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  longint      ref_mem[DP][AS];
  logic [AW-1:0] stim[DP][AS];
  bit          exp_sat;

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: each pass overwrites or saturating-adds per lane; last passes emit every row.
  function automatic void model_pass(input int rows, input bit first, input bit last);
    exp_t e;
    longint v, s;
    exp_sat = 1'b0;
    for (int r = 0; r < rows; r++) begin
      for (int j = 0; j < AS; j++) begin
        v = longint'($signed(stim[r][j]));
        if (first) begin
          s = v;
        end else begin
          s = ref_mem[r][j] + v;
          if (s > SMAX) begin s = SMAX; exp_sat = 1'b1; end
          if (s < SMIN) begin s = SMIN; exp_sat = 1'b1; end
        end
        ref_mem[r][j] = s;
      end
    end
    if (last) begin
      for (int r = 0; r < rows; r++) begin
        for (int j = 0; j < AS; j++) begin
          v = ref_mem[r][j];
          e.data[j*AW +: AW] = v[AW-1:0];
        end
        e.last = (r == rows - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic fill_stim(input int rows, input int kind, input logic [AW-1:0] c);
    for (int r = 0; r < rows; r++) begin
      for (int j = 0; j < AS; j++) begin
        case (kind)
          0: stim[r][j] = AW'($urandom_range(0, 2000)) - AW'(1000);
          1: stim[r][j] = $urandom;
          default: stim[r][j] = c;
        endcase
      end
    end
  endtask

  // Monitor: pops an expected row on every output handshake, checks hold during stalls.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (stall_prev && out_valid) check_vec("out_hold", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_int("unexpected_row", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_vec("out_data", out_data, e.data);
          check_int("out_last", int'(out_last), int'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic run_pass(input int rows, input bit first, input bit last,
                          input int rmode, input bit gap, input int abort_hs);
    int  sent, lat, hs, dc;
    bit  seen, pend_hs;
    bit  pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; lat = 0; hs = 0; dc = 0; seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_rows = 7'(rows);
    cfg_first = first;
    cfg_last = last;
    in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b0;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    pend_hs = 1'b0;
    model_pass(rows, first, last);
    while (!seen && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (pend_hs) hs++;
      if (abort_hs > 0 && hs == abort_hs) begin
        out_ready = 1'b0;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_int("rst_out_valid", int'(out_valid), 0);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_done", int'(done), 0);
        exp_q.delete();
        return;
      end
      if (lat == 1 && rows > 0) check_int("in_ready_rise", int'(in_ready), 1);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (in_ready && sent < rows) begin
          if (gap && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
          end else begin
            in_valid = 1'b1;
            for (int j = 0; j < AS; j++) in_data[j*AW +: AW] = stim[sent][j];
            sent++;
          end
        end else begin
          in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b0;
          in_data = {$urandom, $urandom, $urandom, $urandom};
        end
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = 1'($urandom_range(0, 1));
          default: begin
            out_ready = out_valid ? pat[dc % 4] : 1'b1;
            if (out_valid) dc++;
          end
        endcase
        pend_hs = out_valid && out_ready;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_int("done_seen", int'(seen), 1);
    if (rmode == 0 && !gap && (last || rows == 0))
      check_int("latency", lat, (rows == 0) ? 1 : 1 + 2 * rows);
    check_int("sat_flag", int'(sat_flag), int'(exp_sat));
    check_int("rows_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    check_int("done_pulse", int'(done), 0);
    check_int("idle_busy", int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_sat", int'(sat_flag), 0);
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_out_last", int'(out_last), 0);
    check_vec("rst_out_data", out_data, '0);
    rst = 1'b0;

    // Single pass: lane0 carries 1,2,3.
    fill_stim(3, 2, '0);
    for (int r = 0; r < 3; r++) stim[r][0] = AW'(r + 1);
    run_pass(3, 1'b1, 1'b1, 0, 1'b0, 0);

    // Two-pass accumulate with IDLE-time garbage between the passes.
    fill_stim(8, 2, 32'd10);
    run_pass(8, 1'b1, 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    fill_stim(8, 2, 32'd5);
    run_pass(8, 1'b0, 1'b1, 0, 1'b0, 0);

    // Saturation toward both rails.
    fill_stim(2, 2, 32'h7FFF_FFF0);
    for (int j = 0; j < AS; j++) stim[1][j] = 32'h8000_0005;
    run_pass(2, 1'b1, 1'b0, 0, 1'b0, 0);
    fill_stim(2, 2, 32'h0000_0020);
    for (int j = 0; j < AS; j++) stim[1][j] = 32'hFFFF_FFF0;
    run_pass(2, 1'b0, 1'b1, 0, 1'b0, 0);

    // Drain backpressure 1,0,0,1.
    fill_stim(6, 1, '0);
    run_pass(6, 1'b1, 1'b1, 2, 1'b0, 0);

    // Empty pass.
    run_pass(0, 1'b1, 1'b1, 0, 1'b0, 0);

    // Full depth, two passes, random gaps and ready.
    fill_stim(DP, 0, '0);
    run_pass(DP, 1'b1, 1'b0, 1, 1'b1, 0);
    fill_stim(DP, 1, '0);
    run_pass(DP, 1'b0, 1'b1, 1, 1'b1, 0);

    // Random passes over the now fully written buffer.
    for (int p = 0; p < 8; p++) begin
      int rows;
      rows = $urandom_range(1, DP);
      fill_stim(rows, $urandom_range(0, 1), '0);
      run_pass(rows, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end

    // Reset after two drained rows, then a fresh single pass.
    fill_stim(4, 1, '0);
    run_pass(4, 1'b1, 1'b1, 0, 1'b0, 2);
    fill_stim(4, 0, '0);
    run_pass(4, 1'b1, 1'b1, 0, 1'b0, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
